// File: rtl/int_flag_stack.sv
// Interrupt flag context LIFO: saves C/Z on interrupt entry and replays them to the flag register on return.
// Optional macro INTSTK_IE_SAVE_EN widens entries to {c,z,ie} and adds ie_i/ie_o.
module int_flag_stack #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             save_req,
    input  logic             reti_req,
    input  logic             c_i,
    input  logic             z_i,
`ifdef INTSTK_IE_SAVE_EN
    input  logic             ie_i,
    output logic             ie_o,
`endif
    input  logic             err_clr,
    output logic             intc_o,
    output logic             intz_o,
    output logic             iwe_o,
    output logic [CNT_W-1:0] depth_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef INTSTK_IE_SAVE_EN
    localparam int ENTRY_W = 3;
    localparam logic [ENTRY_W-1:0] REST_RST = 3'b001;
`else
    localparam int ENTRY_W = 2;
    localparam logic [ENTRY_W-1:0] REST_RST = 2'b00;
`endif

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [ENTRY_W-1:0] rest_q, rest_d;
    logic [CNT_W-1:0]   depth_q, depth_d;
    logic               iwe_q, iwe_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic [ENTRY_W-1:0] live_flags;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   top_idx;
    logic               is_full;
    logic               is_empty;

`ifdef INTSTK_IE_SAVE_EN
    assign live_flags = {c_i, z_i, ie_i};
`else
    assign live_flags = {c_i, z_i};
`endif

    assign is_full  = (depth_q == CNT_W'(DEPTH));
    assign is_empty = (depth_q == '0);
    assign wr_idx   = IDX_W'(depth_q);
    assign top_idx  = IDX_W'(depth_q - CNT_W'(1));

    always_comb begin
        mem_d   = mem_q;
        rest_d  = rest_q;
        depth_d = depth_q;
        iwe_d   = iwe_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clk_en) begin
            iwe_d = 1'b0;
            // Clear first so an error raised on this same edge still wins.
            if (err_clr) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            unique case ({save_req, reti_req})
                2'b10: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_d[wr_idx] = live_flags;
                        depth_d       = depth_q + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        rest_d  = mem_q[top_idx];
                        iwe_d   = 1'b1;
                        depth_d = depth_q - CNT_W'(1);
                    end
                end
                2'b11: begin
                    // Tail-chained interrupt: restore the old context and replace it in place.
                    if (is_empty) begin
                        unf_d         = 1'b1;
                        mem_d[wr_idx] = live_flags;
                        depth_d       = depth_q + CNT_W'(1);
                    end else begin
                        rest_d         = mem_q[top_idx];
                        iwe_d          = 1'b1;
                        mem_d[top_idx] = live_flags;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rest_q  <= REST_RST;
            depth_q <= '0;
            iwe_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            rest_q  <= rest_d;
            depth_q <= depth_d;
            iwe_q   <= iwe_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry storage needs no reset: only slots below depth_q are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign intc_o  = rest_q[ENTRY_W-1];
    assign intz_o  = rest_q[ENTRY_W-2];
`ifdef INTSTK_IE_SAVE_EN
    assign ie_o    = rest_q[0];
`endif
    assign iwe_o   = iwe_q;
    assign depth_o = depth_q;
    assign full_o  = is_full;
    assign empty_o = is_empty;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: tb/tb_int_flag_stack.sv
// Directed bench for int_flag_stack (DEPTH=4): vector table plus clock-enable and async-reset sequences.
module tb_int_flag_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en, save_req, reti_req, c_i, z_i, err_clr;
    logic       intc_o, intz_o, iwe_o, full_o, empty_o, ovf_o, unf_o;
    logic [2:0] depth_o;
`ifdef INTSTK_IE_SAVE_EN
    logic       ie_i = 1'b0;
    logic       ie_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    int_flag_stack #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .save_req (save_req),
        .reti_req (reti_req),
        .c_i      (c_i),
        .z_i      (z_i),
`ifdef INTSTK_IE_SAVE_EN
        .ie_i     (ie_i),
        .ie_o     (ie_o),
`endif
        .err_clr  (err_clr),
        .intc_o   (intc_o),
        .intz_o   (intz_o),
        .iwe_o    (iwe_o),
        .depth_o  (depth_o),
        .full_o   (full_o),
        .empty_o  (empty_o),
        .ovf_o    (ovf_o),
        .unf_o    (unf_o)
    );

    typedef struct {
        logic       en, save, reti, c, z, clr;
        logic       ic, iz, iwe;
        logic [2:0] dep;
        logic       ovf, unf;
    } vec_t;

    vec_t vecs[30];

    function automatic vec_t mk(input logic en, save, reti, c, z, clr,
                                input logic ic, iz, iwe, input logic [2:0] dep,
                                input logic ovf, unf);
        vec_t v;
        v.en = en; v.save = save; v.reti = reti; v.c = c; v.z = z; v.clr = clr;
        v.ic = ic; v.iz = iz; v.iwe = iwe; v.dep = dep; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic ic, iz, iwe,
                       input logic [2:0] dep, input logic ovf, unf);
        logic exp_full, exp_empty;
        exp_full  = (dep == 3'd4);
        exp_empty = (dep == 3'd0);
        n_vec++;
        if ({intc_o, intz_o, iwe_o, depth_o, full_o, empty_o, ovf_o, unf_o} !==
            {ic, iz, iwe, dep, exp_full, exp_empty, ovf, unf}) begin
            n_err++;
            $display("FAIL %s: got c=%b z=%b iwe=%b dep=%0d full=%b empty=%b ovf=%b unf=%b; want c=%b z=%b iwe=%b dep=%0d full=%b empty=%b ovf=%b unf=%b",
                     nm, intc_o, intz_o, iwe_o, depth_o, full_o, empty_o, ovf_o, unf_o,
                     ic, iz, iwe, dep, exp_full, exp_empty, ovf, unf);
        end
    endtask

    task automatic drive(input logic en, save, reti, c, z, clr);
        clk_en = en; save_req = save; reti_req = reti; c_i = c; z_i = z; err_clr = clr;
    endtask

    initial begin
        //              en sv rt c  z  clr  ic iz iwe dep ovf unf
        vecs[0]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 0, 1, 0, 0,   0, 0, 0, 1, 0, 0);
        vecs[6]  = mk(1, 1, 0, 0, 1, 0,   0, 0, 0, 2, 0, 0);
        vecs[7]  = mk(1, 0, 1, 0, 0, 0,   0, 1, 1, 1, 0, 0);
        vecs[8]  = mk(1, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, 1, 0, 1, 1, 0,   1, 0, 0, 1, 0, 0);
        vecs[11] = mk(1, 1, 0, 1, 1, 0,   1, 0, 0, 2, 0, 0);
        vecs[12] = mk(1, 1, 0, 1, 1, 0,   1, 0, 0, 3, 0, 0);
        vecs[13] = mk(1, 1, 0, 1, 1, 0,   1, 0, 0, 4, 0, 0);
        vecs[14] = mk(1, 1, 0, 1, 1, 0,   1, 0, 0, 4, 1, 0);
        vecs[15] = mk(1, 0, 0, 0, 0, 1,   1, 0, 0, 4, 0, 0);
        vecs[16] = mk(1, 0, 1, 0, 0, 0,   1, 1, 1, 3, 0, 0);
        vecs[17] = mk(1, 0, 1, 0, 0, 0,   1, 1, 1, 2, 0, 0);
        vecs[18] = mk(1, 0, 1, 0, 0, 0,   1, 1, 1, 1, 0, 0);
        vecs[19] = mk(1, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0, 0);
        vecs[20] = mk(1, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 1);
        vecs[21] = mk(1, 1, 1, 1, 0, 0,   1, 1, 0, 1, 0, 1);
        vecs[22] = mk(1, 0, 0, 0, 0, 1,   1, 1, 0, 1, 0, 0);
        vecs[23] = mk(1, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0);
        vecs[24] = mk(1, 1, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        vecs[25] = mk(1, 1, 1, 1, 1, 0,   0, 0, 1, 1, 0, 0);
        vecs[26] = mk(1, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0, 0);
        vecs[27] = mk(1, 1, 1, 0, 1, 1,   1, 1, 0, 1, 0, 1);
        vecs[28] = mk(1, 0, 0, 0, 0, 1,   1, 1, 0, 1, 0, 0);
        vecs[29] = mk(0, 1, 0, 1, 1, 0,   1, 1, 0, 1, 0, 0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("reset", 0, 0, 0, 0, 0, 0);
        #10 rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            drive(vecs[i].en, vecs[i].save, vecs[i].reti, vecs[i].c, vecs[i].z, vecs[i].clr);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d", i), vecs[i].ic, vecs[i].iz, vecs[i].iwe,
                vecs[i].dep, vecs[i].ovf, vecs[i].unf);
        end

        // Fresh reset, then clock-enable gating and async reset mid-restore.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("reset2", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        drive(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("gated_push%0d", i), 0, 0, 0, 0, 0, 0);
        end

        drive(1, 1, 0, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("push_active", 0, 0, 0, 1, 0, 0);

        drive(1, 0, 1, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("pop_active", 1, 0, 1, 0, 0, 0);

        drive(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("iwe_hold%0d", i), 1, 0, 1, 0, 0, 0);
        end

        drive(1, 1, 0, 1, 1, 0);
        @(posedge clk);
        @(negedge clk);
        chk("push_after_hold", 1, 0, 0, 1, 0, 0);

        drive(1, 0, 1, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("pop_before_rst", 1, 1, 1, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
